// File: rtl/audio_sample_feeder.sv
// Audio sample feeder: buffers demodulated samples in a small FIFO and releases one
// rounded, saturated sample to the PWM stage every 2^PERIOD_WIDTH clocks.
module audio_sample_feeder #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 12,
  parameter int PERIOD_WIDTH = 10,
  parameter int DEPTH_LOG2   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    out_strobe,
  output logic [DEPTH_LOG2:0]     fill_level,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clear_flags
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam int SW    = INPUT_WIDTH + 1;

  localparam logic signed [SW-1:0] RND  = SW'(2 ** (SHIFT - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (OUTPUT_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (OUTPUT_WIDTH - 1)));

  // Round half up, drop SHIFT LSBs, clamp to the output range.
  function automatic logic signed [OUTPUT_WIDTH-1:0] convert(
    input logic signed [INPUT_WIDTH-1:0] x
  );
    logic signed [SW-1:0]           sum;
    logic signed [SW-1:0]           shr;
    logic signed [OUTPUT_WIDTH-1:0] res;
    sum = {x[INPUT_WIDTH-1], x} + RND;
    shr = sum >>> SHIFT;
    if (shr > MAXV)      res = MAXV[OUTPUT_WIDTH-1:0];
    else if (shr < MINV) res = MINV[OUTPUT_WIDTH-1:0];
    else                 res = shr[OUTPUT_WIDTH-1:0];
    return res;
  endfunction

  logic [PERIOD_WIDTH-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2:0]            wr_q, wr_d;
  logic [DEPTH_LOG2:0]            rd_q, rd_d;
  logic [INPUT_WIDTH-1:0]         mem_q [DEPTH];
  logic signed [OUTPUT_WIDTH-1:0] dout_q, dout_d;
  logic                           strobe_q;
  logic                           ovf_q, ovf_d;
  logic                           unf_q, unf_d;
  logic                           tick, full, empty, push, pop;

  always_comb begin
    tick  = &cnt_q;
    empty = (wr_q == rd_q);
    full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
            (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
    // Full always blocks a push, even when a pop happens in the same cycle.
    in_ready = ~full & ~rst;
    push     = in_valid & in_ready;
    pop      = tick & ~empty;

    cnt_d  = cnt_q + 1'b1;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop  ? rd_q + 1'b1 : rd_q;
    dout_d = pop  ? convert($signed(mem_q[rd_q[DEPTH_LOG2-1:0]])) : dout_q;

    // A new set event outranks a simultaneous clear.
    ovf_d = (in_valid & full) | (ovf_q & ~clear_flags);
    unf_d = (tick & empty)    | (unf_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      dout_q   <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      dout_q   <= dout_d;
      strobe_q <= tick;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= in_data;
  end

  assign data_out   = dout_q;
  assign out_strobe = strobe_q;
  assign fill_level = wr_q - rd_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Bench for audio_sample_feeder: a cycle model with an expected-sample queue plus
// table-driven conversion vectors and hand sequences for FIFO/reset corner cases.
module tb_audio_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] data_out;
  logic        out_strobe;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        underflow;
  logic        clear_flags;

  audio_sample_feeder #(
    .INPUT_WIDTH(16), .OUTPUT_WIDTH(12), .PERIOD_WIDTH(10), .DEPTH_LOG2(3)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_strobe(out_strobe), .fill_level(fill_level),
    .overflow(overflow), .underflow(underflow), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Cycle model state
  int m_cnt;
  int m_q[$];
  int m_dout;
  bit m_strobe, m_ovf, m_unf;
  int push_exp;

  typedef struct {
    logic [15:0] din;
    int          exp;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int conv(input int x);
    int v, q;
    v = x + 8;
    q = (v >= 0) ? v / 16 : -((-v + 15) / 16);
    if (q > 2047)  q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  // Advance one clock, update the model, then compare strobe and popped sample.
  task automatic clk1();
    bit tick, full, empty;
    if (rst) begin
      m_cnt = 0; m_q.delete(); m_dout = 0; m_strobe = 0; m_ovf = 0; m_unf = 0;
    end else begin
      tick  = (m_cnt == 1023);
      full  = (m_q.size() == 8);
      empty = (m_q.size() == 0);
      if (tick && !empty) m_dout = m_q.pop_front();
      if (in_valid && !full) m_q.push_back(push_exp);
      if (in_valid && full) m_ovf = 1; else if (clear_flags) m_ovf = 0;
      if (tick && empty)    m_unf = 1; else if (clear_flags) m_unf = 0;
      m_strobe = tick;
      m_cnt    = (m_cnt + 1) % 1024;
    end
    @(posedge clk); #1;
    if (out_strobe || m_strobe) chk("strobe", int'(out_strobe), int'(m_strobe));
    if (m_strobe) chk("dout_at_strobe", int'($signed(data_out)), m_dout);
  endtask

  task automatic push1(input logic [15:0] d, input int e);
    in_valid = 1'b1; in_data = d; push_exp = e;
    clk1();
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    bit seen = 0;
    for (int k = 0; k < 1100 && !seen; k++) begin
      clk1();
      if (out_strobe) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic count_to_strobe(input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 1100) begin
      clk1();
      n++;
      if (out_strobe) seen = 1;
    end
    chk(name, n, 1024);
  endtask

  task automatic clear_pulse();
    clear_flags = 1'b1;
    clk1();
    clear_flags = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{16'h7FFF,  2047};
    tbl[1]  = '{16'h8000, -2048};
    tbl[2]  = '{16'h0008,     1};
    tbl[3]  = '{16'hFFF7,    -1};
    tbl[4]  = '{16'h0000,     0};
    tbl[5]  = '{16'h0007,     0};
    tbl[6]  = '{16'hFFF8,     0};
    tbl[7]  = '{16'h7FE7,  2046};
    tbl[8]  = '{16'h8008, -2047};
    tbl[9]  = '{16'h0018,     2};
    tbl[10] = '{16'hFFE8,    -1};
    tbl[11] = '{16'hFFE7,    -2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear_flags = 1'b0; push_exp = 0;
    #2;
    for (int i = 0; i < 3; i++) clk1();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_data_out", int'($signed(data_out)), 0);
    chk("rst_strobe", int'(out_strobe), 0);
    chk("rst_flags", int'({overflow, underflow}), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_fill", int'(fill_level), 0);

    // No data: first period is an underflow
    count_to_strobe("first_strobe_cycle");
    chk("underflow_first", int'(underflow), 1);
    chk("dout_first", int'($signed(data_out)), 0);
    clear_pulse();
    chk("unf_cleared", int'(underflow), 0);

    // Conversion vectors, one per period
    for (int i = 0; i < 12; i++) begin
      push1(tbl[i].din, tbl[i].exp);
      chk($sformatf("fill_after_push%0d", i), int'(fill_level), 1);
      wait_strobe($sformatf("conv%0d", i));
      chk($sformatf("conv%0d_dout", i), int'($signed(data_out)), tbl[i].exp);
    end
    chk("unf_after_table", int'(underflow), int'(m_unf));

    // Push exactly on a tick with an empty FIFO
    for (int k = 0; k < 1100 && m_cnt != 1023; k++) clk1();
    push1(16'h0010, 1);
    chk("tick_push_fill", int'(fill_level), 1);
    chk("tick_push_unf", int'(underflow), 1);
    wait_strobe("tick_push");
    chk("tick_push_dout", int'($signed(data_out)), 1);

    // Nine back-to-back pushes into an empty FIFO
    clear_pulse();
    chk("flags_clear", int'({overflow, underflow}), 0);
    for (int i = 0; i < 9; i++) begin
      logic [15:0] d;
      d = (i == 8) ? 16'h7000 : 16'(16'h0100 * (i + 1));
      push1(d, conv(int'($signed(d))));
      if (i < 8) chk($sformatf("in_ready_after%0d", i + 1), int'(in_ready), (i + 1 < 8) ? 1 : 0);
    end
    chk("full_fill", int'(fill_level), 8);
    chk("overflow_set", int'(overflow), 1);
    clear_pulse();
    chk("ovf_cleared", int'(overflow), 0);
    clear_flags = 1'b1;
    push1(16'h7001, 0);
    clear_flags = 1'b0;
    chk("ovf_set_wins", int'(overflow), 1);
    chk("full_fill_still", int'(fill_level), 8);

    // Drain three, then reset mid-period with five queued
    for (int i = 0; i < 3; i++) wait_strobe($sformatf("drain%0d", i));
    chk("drain_dout", int'($signed(data_out)), 48);
    chk("fill_before_rst", int'(fill_level), 5);
    for (int k = 0; k < 500; k++) clk1();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    #1;
    chk("rst_mid_fill", int'(fill_level), 0);
    chk("rst_mid_dout", int'($signed(data_out)), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    count_to_strobe("strobe_after_mid_rst");

    // Continuous push on every tick keeps occupancy constant
    for (int i = 0; i < 3; i++) begin
      logic [15:0] d;
      d = 16'((i + 1) * 16'h2345) ^ 16'hA5A5;
      push1(d, conv(int'($signed(d))));
    end
    for (int p = 0; p < 6; p++) begin
      logic [15:0] d;
      for (int k = 0; k < 1100 && m_cnt != 1023; k++) clk1();
      d = 16'((p + 7) * 16'h1F3D) ^ 16'h5A5A;
      push1(d, conv(int'($signed(d))));
      chk($sformatf("steady_fill%0d", p), int'(fill_level), 3);
    end
    for (int i = 0; i < 3; i++) wait_strobe($sformatf("final_drain%0d", i));
    chk("final_fill", int'(fill_level), 0);
    chk("final_model_empty", int'(fill_level), m_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_feeder.md
AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

Interface
REQ-001 The block SHALL have parameter INPUT_WIDTH, default 16, giving the width of the signed demodulated sample input.
REQ-002 The block SHALL have parameter OUTPUT_WIDTH, default 12, giving the width of the signed sample delivered to the PWM stage; it SHALL be less than INPUT_WIDTH.
REQ-003 The block SHALL have parameter PERIOD_WIDTH, default 10, so that the output update period is 2^PERIOD_WIDTH clocks.
REQ-004 The block SHALL have parameter DEPTH_LOG2, default 3, so that the FIFO depth is 2^DEPTH_LOG2 entries.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-007 The block SHALL have port in_data, input, INPUT_WIDTH bits, the two's-complement sample from the upstream demodulator.
REQ-008 The block SHALL have port in_valid, input, 1 bit, which is high when in_data holds a new sample.
REQ-009 The block SHALL have port in_ready, output, 1 bit, which is high when the FIFO can accept a sample.
REQ-010 The block SHALL have port data_out, output, OUTPUT_WIDTH bits, the registered two's-complement sample for the PWM stage.
REQ-011 The block SHALL have port out_strobe, output, 1 bit, a one-cycle pulse in the cycle after data_out is reloaded.
REQ-012 The block SHALL have port fill_level, output, DEPTH_LOG2+1 bits, giving the current FIFO occupancy.
REQ-013 The block SHALL have port overflow, output, 1 bit, a sticky flag for a dropped input sample.
REQ-014 The block SHALL have port underflow, output, 1 bit, a sticky flag for a period that found the FIFO empty.
REQ-015 The block SHALL have port clear_flags, input, 1 bit, which clears overflow and underflow synchronously.

Function
REQ-016 The block SHALL keep a free-running period counter of PERIOD_WIDTH bits that counts 0 to 2^PERIOD_WIDTH-1 and wraps to 0; the tick is the cycle in which the counter equals its maximum.
REQ-017 A push SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal the inverse of full and is combinational from registered state only.
REQ-018 When in_valid is high while the FIFO is full, the sample SHALL be discarded and overflow SHALL be set on the next edge.
REQ-019 On a tick with the FIFO non-empty, the head SHALL be popped and data_out SHALL load the converted head on that edge; out_strobe SHALL be high for exactly the following cycle, in which the counter equals 0.
REQ-020 On a tick with the FIFO empty, data_out SHALL hold its previous value, underflow SHALL be set, and out_strobe SHALL still pulse.
REQ-021 The conversion SHALL be: SHIFT = INPUT_WIDTH-OUTPUT_WIDTH; sum = in + 2^(SHIFT-1), computed in INPUT_WIDTH+1 bits; arithmetic shift right by SHIFT; saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
REQ-022 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL leave fill_level unchanged and lose no data.
REQ-023 A push and a tick in the same cycle on an empty FIFO SHALL count as an underflow; the pushed sample SHALL be stored and fill_level SHALL become 1.
REQ-024 When the FIFO is full, in_ready SHALL be 0 even in a tick cycle; a push SHALL never bypass full.
REQ-025 FIFO read and write pointers SHALL be DEPTH_LOG2+1 bits wide with wrap bits; full and empty SHALL be decoded from the pointers, and fill_level = wr_ptr - rd_ptr.
REQ-026 When clear_flags is high, both flags SHALL clear; when clear_flags and a new set event occur in the same cycle, the set SHALL win.
REQ-027 Samples SHALL leave the FIFO in arrival order, with at most one pop per period.

Reset
REQ-028 While rst is high, the block SHALL force the period counter to 0, both pointers to 0, data_out to 0, out_strobe to 0, overflow to 0, underflow to 0, and in_ready to 0.
REQ-029 In the first cycle after rst falls, in_ready SHALL be 1 and fill_level SHALL be 0; the first tick SHALL occur 2^PERIOD_WIDTH-1 cycles later.
REQ-030 Assertion of rst mid-operation SHALL discard all FIFO contents, and no out_strobe SHALL be issued for the interrupted period.

Verification
REQ-031 The bench SHALL push 0x7FFF, 0x8000, 0x0008, 0xFFF7 at INPUT_WIDTH=16 and OUTPUT_WIDTH=12, and SHALL check that data_out is 2047, -2048, 1, -1 on successive strobes.
REQ-032 The bench SHALL push 9 samples back-to-back into an empty 8-deep FIFO before any tick, and SHALL check that in_ready falls after 8 pushes, fill_level=8, overflow=1, and the ninth sample never appears.
REQ-033 The bench SHALL push no data after reset, and SHALL check that the first strobe arrives at cycle 1024, data_out=0, and underflow=1.
REQ-034 The bench SHALL drive a continuous push on every tick cycle, and SHALL check that fill_level stays constant and the output order matches the input order.
REQ-035 The bench SHALL assert rst for 1 cycle with 5 entries queued, and SHALL check that fill_level=0, data_out=0, and the next strobe arrives 1024 cycles after rst falls.
REQ-036 The bench SHALL assert clear_flags in the same cycle as an overflow event, and SHALL check that overflow=1 afterwards.
